pc_hazard_controller: RTL and testbench
=======================================

# pc_hazard_controller

Sequencing controller for the 64-bit program counter and the IF/ID and ID/EX pipeline registers of the 5-stage core. Each cycle it decides whether the PC advances, holds or redirects. It generates the PC write enable, next-PC value and pipeline stall/flush controls for load-use hazards, taken branches, instruction-memory wait states and halt draining. It also keeps saturating stall and flush performance counters.

## Interface
- XLEN, 64, PC and target width
- PC_INC, 4, sequential PC increment
- RESET_PC, 0, next-PC value driven during reset
- DRAIN_CYCLES, 3, cycles spent draining after halt decode (>=1)
- CNT_W, 32, width of performance counters

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- pc_current  in  XLEN  current PC register value
- imem_ready  in  1  instruction memory returned valid instruction this cycle
- if_id_rs1  in  5  source register 1 of instruction in ID
- if_id_rs2  in  5  source register 2 of instruction in ID
- if_id_halt  in  1  ID holds decoded ecall/ebreak
- id_ex_mem_read  in  1  EX-stage instruction is a load
- id_ex_rd  in  5  EX-stage destination register
- ex_branch_taken  in  1  branch/jump resolved taken in EX
- ex_branch_target  in  XLEN  resolved target
- pc_next  out  XLEN  value to load into PC
- pc_write  out  1  PC write enable (low = hold)
- if_id_write  out  1  IF/ID write enable
- if_id_flush  out  1  load bubble into IF/ID
- id_ex_flush  out  1  load bubble into ID/EX
- halted  out  1  core halted
- stall_cycles  out  CNT_W  saturating stall-cycle count
- flush_cycles  out  CNT_W  saturating branch-flush count

## Operation
- States: BOOT, RUN, DRAIN, HALTED. Registers: state, drain counter, two counters.
- While reset=1, outputs are pc_next=RESET_PC, pc_write=0, if_id_write=0, if_id_flush=1 and id_ex_flush=1. At the reset edge: state<=BOOT, counters<=0, halted<=0.
- BOOT lasts one cycle: pc_write=0, if_id_flush=1, pc_next=pc_current. The PC stays at its post-reset value. Next state is RUN.
- RUN applies one action per cycle, in priority order:
  1. ex_branch_taken: pc_next=ex_branch_target, pc_write=1, if_id_write=1, if_id_flush=1, id_ex_flush=1, flush_cycles+1. This also squashes any halt or load-use condition in ID.
  2. load-use (id_ex_mem_read && id_ex_rd!=0 && (id_ex_rd==if_id_rs1 || id_ex_rd==if_id_rs2)): pc_write=0, if_id_write=0, id_ex_flush=1, stall_cycles+1.
  3. if_id_halt: pc_write=0, if_id_flush=1. The halt instruction proceeds to EX. Drain counter<=DRAIN_CYCLES, state<=DRAIN.
  4. !imem_ready: pc_write=0, if_id_flush=1, stall_cycles+1.
  5. Otherwise: pc_next=pc_current+PC_INC (modulo 2^XLEN), pc_write=1, if_id_write=1.
- DRAIN: pc_write=0, if_id_flush=1 and id_ex_flush=1. The counter decrements each cycle; when it equals 1, state<=HALTED. ex_branch_taken, imem_ready and hazard inputs are ignored.
- HALTED: pc_write=0, if_id_write=0, both flushes=1, halted=1. Counters are frozen. Only reset exits this state.
- Default outputs in any state not listed above: pc_next=pc_current, if_id_write=1, flushes=0.
- Counters saturate at all-ones. Neither counter changes in BOOT, DRAIN or HALTED.

## Timing
- All control outputs are combinational from state and the current-cycle inputs. This allows the PC and pipeline registers to act on the same rising edge, so hazard response latency is 0 cycles.
- halted, state and the counters are registered and change on the edge after the triggering cycle.
- A redirect takes effect on the next edge, and the target instruction is fetched the following cycle. Exactly one bubble is inserted into each of IF/ID and ID/EX per taken branch.
- A load-use hazard stalls for exactly one cycle. The following cycle the load is in MEM and the condition clears without further action.
- Reset asserted mid-DRAIN or in HALTED returns the block to BOOT at the next edge.

## Test plan
- Reset held 2 cycles, then released with pc_current=0: cycle 1 gives pc_write=0 (BOOT). Cycle 2 gives pc_write=1, pc_next=0x4, and counters read 0.
- id_ex_mem_read=1, id_ex_rd=5, if_id_rs2=5 for one cycle: pc_write=0, if_id_write=0, id_ex_flush=1, then stall_cycles=1. Repeating with id_ex_rd=0 gives no stall.
- ex_branch_taken=1 with target 0x100 while a load-use condition is also true: pc_next=0x100, pc_write=1, both flushes=1. Afterwards flush_cycles=1 and stall_cycles is unchanged.
- imem_ready=0 for 3 cycles: pc_write=0 and if_id_flush=1 in each cycle, stall_cycles increases by 3, and the PC advances by 4 on the cycle imem_ready returns.
- if_id_halt pulse with DRAIN_CYCLES=3: one RUN cycle, then 3 DRAIN cycles with pc_write=0 even while ex_branch_taken=1, then halted=1 held for 10 cycles. A subsequent reset clears halted and returns to BOOT.
- With CNT_W=4, 20 consecutive imem_ready=0 cycles leave stall_cycles at 15 (saturated).

Source files
------------

// File: rtl/pc_hazard_controller_if.sv
// pc_hazard_controller_if
// Bundles the PC / pipeline-register control signals exchanged between the
// core datapath and the hazard controller.
//   master : datapath side (drives PC value, decode/execute hazard info,
//            consumes PC and pipeline-register controls)
//   slave  : controller side (pc_hazard_controller)
// Signals:
//   pc_current, imem_ready, if_id_rs1/rs2, if_id_halt, id_ex_mem_read,
//   id_ex_rd, ex_branch_taken, ex_branch_target   -> controller
//   pc_next, pc_write, if_id_write, if_id_flush, id_ex_flush, halted,
//   stall_cycles, flush_cycles                    <- controller
interface pc_hazard_controller_if #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 32
);
    logic [XLEN-1:0]  pc_current;
    logic             imem_ready;
    logic [4:0]       if_id_rs1;
    logic [4:0]       if_id_rs2;
    logic             if_id_halt;
    logic             id_ex_mem_read;
    logic [4:0]       id_ex_rd;
    logic             ex_branch_taken;
    logic [XLEN-1:0]  ex_branch_target;

    logic [XLEN-1:0]  pc_next;
    logic             pc_write;
    logic             if_id_write;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             halted;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_cycles;

    modport master (
        output pc_current, imem_ready, if_id_rs1, if_id_rs2, if_id_halt,
               id_ex_mem_read, id_ex_rd, ex_branch_taken, ex_branch_target,
        input  pc_next, pc_write, if_id_write, if_id_flush, id_ex_flush,
               halted, stall_cycles, flush_cycles
    );

    modport slave (
        input  pc_current, imem_ready, if_id_rs1, if_id_rs2, if_id_halt,
               id_ex_mem_read, id_ex_rd, ex_branch_taken, ex_branch_target,
        output pc_next, pc_write, if_id_write, if_id_flush, id_ex_flush,
               halted, stall_cycles, flush_cycles
    );
endinterface

// File: rtl/pc_hazard_controller.sv
// pc_hazard_controller
// Decides each cycle whether the PC advances, holds or redirects, and drives
// the IF/ID and ID/EX write/flush controls for load-use hazards, taken
// branches, instruction-memory wait states and halt draining. Keeps
// saturating stall and branch-flush counters.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous active-high reset
//   bus   : pc_hazard_controller_if.slave (hazard inputs, PC/pipeline controls,
//           halted flag and performance counters)
// Control outputs are combinational from state and current inputs so the PC
// and pipeline registers act on the same edge; halted and counters are
// registered.
module pc_hazard_controller #(
    parameter int              XLEN         = 64,
    parameter int              PC_INC       = 4,
    parameter logic [XLEN-1:0] RESET_PC     = '0,
    parameter int              DRAIN_CYCLES = 3,
    parameter int              CNT_W        = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    pc_hazard_controller_if.slave  bus
);
    localparam int DW = $clog2(DRAIN_CYCLES + 1);

    typedef enum logic [1:0] {BOOT, RUN, DRAIN, HALTED} state_t;

    state_t           state;
    logic [DW-1:0]    drain_cnt;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic             halted_q;

    logic [XLEN-1:0]  pc_next;
    logic             pc_write;
    logic             if_id_write;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             stall_inc;
    logic             flush_inc;
    logic             enter_drain;
    logic             load_use;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // x0 is never a real dependency, so rd==0 cannot cause a stall
    assign load_use = bus.id_ex_mem_read && (bus.id_ex_rd != 5'd0) &&
                      ((bus.id_ex_rd == bus.if_id_rs1) ||
                       (bus.id_ex_rd == bus.if_id_rs2));

    always_comb begin
        pc_next     = bus.pc_current;
        pc_write    = 1'b0;
        if_id_write = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;
        enter_drain = 1'b0;
        if (reset) begin
            pc_next     = RESET_PC;
            if_id_write = 1'b0;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else begin
            case (state)
                BOOT: begin
                    if_id_flush = 1'b1;
                end
                RUN: begin
                    // Taken branch wins: it squashes whatever sits in ID,
                    // including a halt or the consumer of a load.
                    if (bus.ex_branch_taken) begin
                        pc_next     = bus.ex_branch_target;
                        pc_write    = 1'b1;
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                        flush_inc   = 1'b1;
                    end else if (load_use) begin
                        if_id_write = 1'b0;
                        id_ex_flush = 1'b1;
                        stall_inc   = 1'b1;
                    end else if (bus.if_id_halt) begin
                        // halt moves on to EX; nothing new enters IF/ID
                        if_id_flush = 1'b1;
                        enter_drain = 1'b1;
                    end else if (!bus.imem_ready) begin
                        if_id_flush = 1'b1;
                        stall_inc   = 1'b1;
                    end else begin
                        pc_next  = bus.pc_current + XLEN'(PC_INC);
                        pc_write = 1'b1;
                    end
                end
                DRAIN: begin
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                end
                HALTED: begin
                    if_id_write = 1'b0;
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= BOOT;
            drain_cnt <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
            halted_q  <= 1'b0;
        end else begin
            case (state)
                BOOT: state <= RUN;
                RUN: begin
                    if (enter_drain) begin
                        state     <= DRAIN;
                        drain_cnt <= DW'(DRAIN_CYCLES);
                    end
                    if (stall_inc) stall_cnt <= sat_inc(stall_cnt);
                    if (flush_inc) flush_cnt <= sat_inc(flush_cnt);
                end
                DRAIN: begin
                    drain_cnt <= drain_cnt - 1'b1;
                    if (drain_cnt == DW'(1)) begin
                        state    <= HALTED;
                        halted_q <= 1'b1;
                    end
                end
                HALTED: ;
                default: state <= BOOT;
            endcase
        end
    end

    assign bus.pc_next      = pc_next;
    assign bus.pc_write     = pc_write;
    assign bus.if_id_write  = if_id_write;
    assign bus.if_id_flush  = if_id_flush;
    assign bus.id_ex_flush  = id_ex_flush;
    assign bus.halted       = halted_q;
    assign bus.stall_cycles = stall_cnt;
    assign bus.flush_cycles = flush_cnt;
endmodule

// File: tb/tb_pc_hazard_controller.sv
// tb_pc_hazard_controller
// Directed bench for pc_hazard_controller. A second instance with CNT_W=4
// shares the stimulus to exercise counter saturation. A small PC register
// loads pc_next on pc_write (or during reset) and feeds pc_current back.
module tb_pc_hazard_controller;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pc_hazard_controller_if #(.XLEN(64), .CNT_W(32)) bus();
    pc_hazard_controller_if #(.XLEN(64), .CNT_W(4))  bus4();

    pc_hazard_controller #(.XLEN(64), .PC_INC(4), .RESET_PC(64'h0),
                           .DRAIN_CYCLES(3), .CNT_W(32))
        dut (.clk(clk), .reset(reset), .bus(bus));

    pc_hazard_controller #(.XLEN(64), .PC_INC(4), .RESET_PC(64'h0),
                           .DRAIN_CYCLES(3), .CNT_W(4))
        dut4 (.clk(clk), .reset(reset), .bus(bus4));

    logic [63:0] pc_reg;
    always_ff @(posedge clk) begin
        if (reset)             pc_reg <= bus.pc_next;
        else if (bus.pc_write) pc_reg <= bus.pc_next;
    end
    assign bus.pc_current = pc_reg;

    assign bus4.pc_current       = pc_reg;
    assign bus4.imem_ready       = bus.imem_ready;
    assign bus4.if_id_rs1        = bus.if_id_rs1;
    assign bus4.if_id_rs2        = bus.if_id_rs2;
    assign bus4.if_id_halt       = bus.if_id_halt;
    assign bus4.id_ex_mem_read   = bus.id_ex_mem_read;
    assign bus4.id_ex_rd         = bus.id_ex_rd;
    assign bus4.ex_branch_taken  = bus.ex_branch_taken;
    assign bus4.ex_branch_target = bus.ex_branch_target;

    int checks   = 0;
    int failures = 0;

    logic [3:0] ctl;
    assign ctl = {bus.pc_write, bus.if_id_write, bus.if_id_flush, bus.id_ex_flush};

    task automatic idle();
        bus.imem_ready       = 1'b1;
        bus.if_id_rs1        = 5'd0;
        bus.if_id_rs2        = 5'd0;
        bus.if_id_halt       = 1'b0;
        bus.id_ex_mem_read   = 1'b0;
        bus.id_ex_rd         = 5'd0;
        bus.ex_branch_taken  = 1'b0;
        bus.ex_branch_target = 64'h0;
    endtask

    // inputs are driven at posedge+1; mid() lands on the negedge for sampling
    task automatic mid();
        #4;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        for (int i = 0; i < 2; i++) begin
            mid();
            checks++;
            if (ctl !== 4'b0011) begin
                failures++;
                $display("FAIL reset_ctl cyc=%0d got=%b exp=0011", i, ctl);
            end
            checks++;
            if (bus.pc_next !== 64'h0) begin
                failures++;
                $display("FAIL reset_pc_next got=%h exp=0", bus.pc_next);
            end
            step();
        end
        reset = 1'b0;
        mid();
        checks++;
        if (ctl !== 4'b0110) begin
            failures++;
            $display("FAIL boot_ctl got=%b exp=0110", ctl);
        end
        checks++;
        if ({bus.halted, bus.stall_cycles, bus.flush_cycles} !== 65'h0) begin
            failures++;
            $display("FAIL boot_regs got halted=%b stall=%0d flush=%0d exp=0/0/0",
                     bus.halted, bus.stall_cycles, bus.flush_cycles);
        end
        step();
        mid();
        checks++;
        if (ctl !== 4'b1100 || bus.pc_next !== 64'h4) begin
            failures++;
            $display("FAIL run_first got ctl=%b pc_next=%h exp ctl=1100 pc_next=4",
                     ctl, bus.pc_next);
        end
        step();
    endtask

    task automatic test_load_use();
        idle();
        bus.id_ex_mem_read = 1'b1; bus.id_ex_rd = 5'd5; bus.if_id_rs2 = 5'd5;
        mid();
        checks++;
        if (ctl !== 4'b0001) begin
            failures++;
            $display("FAIL lu_rs2_ctl got=%b exp=0001", ctl);
        end
        step();
        idle();
        mid();
        checks++;
        if (bus.stall_cycles !== 32'd1 || ctl !== 4'b1100 || bus.pc_next !== 64'h8) begin
            failures++;
            $display("FAIL lu_after got stall=%0d ctl=%b pc_next=%h exp 1/1100/8",
                     bus.stall_cycles, ctl, bus.pc_next);
        end
        step();
        bus.id_ex_mem_read = 1'b1; bus.id_ex_rd = 5'd7; bus.if_id_rs1 = 5'd7;
        mid();
        checks++;
        if (ctl !== 4'b0001) begin
            failures++;
            $display("FAIL lu_rs1_ctl got=%b exp=0001", ctl);
        end
        step();
        idle();
        bus.id_ex_mem_read = 1'b1; bus.id_ex_rd = 5'd0;
        mid();
        checks++;
        if (ctl !== 4'b1100 || bus.stall_cycles !== 32'd2) begin
            failures++;
            $display("FAIL lu_rd0 got ctl=%b stall=%0d exp 1100/2", ctl, bus.stall_cycles);
        end
        step();
        idle();
        bus.id_ex_rd = 5'd5; bus.if_id_rs1 = 5'd5;
        mid();
        checks++;
        if (ctl !== 4'b1100) begin
            failures++;
            $display("FAIL lu_not_load got ctl=%b exp=1100", ctl);
        end
        step();
    endtask

    task automatic test_branch();
        idle();
        bus.id_ex_mem_read = 1'b1; bus.id_ex_rd = 5'd3; bus.if_id_rs1 = 5'd3;
        bus.if_id_halt = 1'b1; bus.imem_ready = 1'b0;
        bus.ex_branch_taken = 1'b1; bus.ex_branch_target = 64'h100;
        mid();
        checks++;
        if (ctl !== 4'b1111 || bus.pc_next !== 64'h100) begin
            failures++;
            $display("FAIL br_ctl got ctl=%b pc_next=%h exp 1111/100", ctl, bus.pc_next);
        end
        step();
        idle();
        mid();
        checks++;
        if (bus.flush_cycles !== 32'd1 || bus.stall_cycles !== 32'd2) begin
            failures++;
            $display("FAIL br_counts got flush=%0d stall=%0d exp 1/2",
                     bus.flush_cycles, bus.stall_cycles);
        end
        checks++;
        if (bus.pc_next !== 64'h104) begin
            failures++;
            $display("FAIL br_redirect got pc_next=%h exp=104", bus.pc_next);
        end
        step();
    endtask

    task automatic test_back_to_back();
        idle();
        bus.ex_branch_taken = 1'b1; bus.ex_branch_target = 64'h200;
        mid();
        checks++;
        if (ctl !== 4'b1111 || bus.pc_next !== 64'h200) begin
            failures++;
            $display("FAIL b2b_first got ctl=%b pc_next=%h exp 1111/200", ctl, bus.pc_next);
        end
        step();
        bus.ex_branch_target = 64'h300;
        mid();
        checks++;
        if (bus.pc_next !== 64'h300 || bus.flush_cycles !== 32'd2) begin
            failures++;
            $display("FAIL b2b_second got pc_next=%h flush=%0d exp 300/2",
                     bus.pc_next, bus.flush_cycles);
        end
        step();
        idle();
        mid();
        checks++;
        if (bus.pc_next !== 64'h304 || bus.flush_cycles !== 32'd3) begin
            failures++;
            $display("FAIL b2b_after got pc_next=%h flush=%0d exp 304/3",
                     bus.pc_next, bus.flush_cycles);
        end
        step();
    endtask

    task automatic test_imem_wait();
        idle();
        bus.imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mid();
            checks++;
            if (ctl !== 4'b0110) begin
                failures++;
                $display("FAIL imem_wait_ctl cyc=%0d got=%b exp=0110", i, ctl);
            end
            step();
        end
        bus.imem_ready = 1'b1;
        mid();
        checks++;
        if (bus.stall_cycles !== 32'd5 || ctl !== 4'b1100 || bus.pc_next !== 64'h308) begin
            failures++;
            $display("FAIL imem_resume got stall=%0d ctl=%b pc_next=%h exp 5/1100/308",
                     bus.stall_cycles, ctl, bus.pc_next);
        end
        step();
    endtask

    task automatic test_saturation();
        idle();
        bus.imem_ready = 1'b0;
        for (int i = 0; i < 20; i++) step();
        bus.imem_ready = 1'b1;
        mid();
        checks++;
        if (bus4.stall_cycles !== 4'd15) begin
            failures++;
            $display("FAIL sat_stall4 got=%0d exp=15", bus4.stall_cycles);
        end
        checks++;
        if (bus.stall_cycles !== 32'd25 || bus4.flush_cycles !== 4'd3) begin
            failures++;
            $display("FAIL sat_other got stall32=%0d flush4=%0d exp 25/3",
                     bus.stall_cycles, bus4.flush_cycles);
        end
        step();
    endtask

    task automatic test_halt();
        idle();
        bus.if_id_halt = 1'b1;
        mid();
        checks++;
        if (ctl !== 4'b0110) begin
            failures++;
            $display("FAIL halt_run_ctl got=%b exp=0110", ctl);
        end
        step();
        idle();
        bus.ex_branch_taken = 1'b1; bus.ex_branch_target = 64'h400;
        bus.imem_ready = 1'b0;
        bus.id_ex_mem_read = 1'b1; bus.id_ex_rd = 5'd5; bus.if_id_rs1 = 5'd5;
        for (int i = 0; i < 3; i++) begin
            mid();
            checks++;
            if (ctl !== 4'b0111 || bus.halted !== 1'b0) begin
                failures++;
                $display("FAIL drain cyc=%0d got ctl=%b halted=%b exp 0111/0",
                         i, ctl, bus.halted);
            end
            step();
        end
        for (int i = 0; i < 10; i++) begin
            mid();
            checks++;
            if (ctl !== 4'b0011 || bus.halted !== 1'b1) begin
                failures++;
                $display("FAIL halted cyc=%0d got ctl=%b halted=%b exp 0011/1",
                         i, ctl, bus.halted);
            end
            step();
        end
        mid();
        checks++;
        if (bus.stall_cycles !== 32'd25 || bus.flush_cycles !== 32'd3) begin
            failures++;
            $display("FAIL halt_frozen got stall=%0d flush=%0d exp 25/3",
                     bus.stall_cycles, bus.flush_cycles);
        end
        step();
        idle();
        reset = 1'b1;
        mid();
        checks++;
        if (ctl !== 4'b0011 || bus.pc_next !== 64'h0) begin
            failures++;
            $display("FAIL rehalt_reset got ctl=%b pc_next=%h exp 0011/0", ctl, bus.pc_next);
        end
        step();
        reset = 1'b0;
        mid();
        checks++;
        if (bus.halted !== 1'b0 || bus.stall_cycles !== 32'd0 || ctl !== 4'b0110) begin
            failures++;
            $display("FAIL rehalt_boot got halted=%b stall=%0d ctl=%b exp 0/0/0110",
                     bus.halted, bus.stall_cycles, ctl);
        end
        step();
        mid();
        checks++;
        if (ctl !== 4'b1100 || bus.pc_next !== 64'h4) begin
            failures++;
            $display("FAIL rehalt_run got ctl=%b pc_next=%h exp 1100/4", ctl, bus.pc_next);
        end
        step();
    endtask

    initial begin
        reset = 1'b1;
        idle();
        @(posedge clk);
        #1;
        test_reset();
        test_load_use();
        test_branch();
        test_back_to_back();
        test_imem_wait();
        test_saturation();
        test_halt();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
